// File: rtl/cp0_pkg.sv
// CP0 shared constants: register numbers, field positions, ExcCodes.
package cp0_pkg;

  typedef logic [31:0] word_t;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_BEV = 22;
  localparam int CA_BD  = 31;
  localparam int CA_TI  = 30;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam word_t STATUS_RST = 32'h0040_0000;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with prescaler; TI sticks until Compare is written.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  count_we,
  input  logic  compare_we,
  input  word_t wdata,
  output word_t count,
  output word_t compare,
  output logic  ti
);

  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div   <= '0;
      count <= '0;
    end else if (count_we) begin
      div   <= '0;
      count <= wdata;
    end else if (div == DIV_LAST) begin
      div   <= '0;
      count <= count + 32'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare <= '0;
      ti      <= 1'b0;
    end else if (compare_we) begin
      compare <= wdata;
      ti      <= 1'b0;
    end else if (count == compare && compare != '0) begin
      ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_mlane.sv
// N-lane commit-stage CP0: exception/interrupt/ERET arbitration and CP0 state.
// Timer built only when CP0_TIMER_EN is defined.
module cp0_mlane
  import cp0_pkg::*;
#(
  parameter int          LANES      = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          COUNT_DIV  = 2,
  localparam int         LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANES-1:0]    commit_valid,
  input  logic [LANES-1:0]    exc_valid,
  input  logic [5*LANES-1:0]  exc_code,
  input  logic [32*LANES-1:0] exc_pc,
  input  logic [LANES-1:0]    exc_bd,
  input  logic [LANES-1:0]    exc_badv_vld,
  input  logic [32*LANES-1:0] exc_badvaddr,
  input  logic [LANES-1:0]    eret,
  input  logic              mtc0_we,
  input  logic [LW-1:0]     mtc0_lane,
  input  logic [4:0]        mtc0_addr,
  input  logic [31:0]       mtc0_wdata,
  input  logic [4:0]        mfc0_addr,
  output logic [31:0]       mfc0_rdata,
  input  logic [5:0]        hw_int,
  output logic              flush,
  output logic [31:0]       flush_pc,
  output logic              int_pending
);

  word_t      badv, epc, count, compare;
  logic [7:0] im;
  logic       exl, ie, bd, ti;
  logic [5:0] ip_hw;
  logic [1:0] ip_sw;
  logic [4:0] code;
  logic [7:0] ip;
  logic       int_req;

  assign ip      = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign int_req = ie & ~exl & |(ip & im);

  logic [LANES-1:0] req;
  logic             req_any, int_take, win_any;
  logic [LW-1:0]    win_idx;

  assign req      = commit_valid & (exc_valid | eret);
  assign int_take = int_pending & commit_valid[0];

  // Scan high to low so the oldest requesting lane ends up selected.
  always_comb begin
    win_idx = '0;
    req_any = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx = LW'(i);
        req_any = 1'b1;
      end
    end
    if (int_take) win_idx = '0;
  end

  logic       take_exc, take_eret, mtc0_ok, epc_fwd;
  word_t      w_pc, w_badv;
  logic       w_bd;
  logic [4:0] w_code;

  assign win_any   = int_take | req_any;
  assign take_exc  = int_take | (req_any & exc_valid[win_idx]);
  assign take_eret = ~int_take & req_any & eret[win_idx] & ~exc_valid[win_idx];
  assign w_pc      = exc_pc[win_idx*32 +: 32];
  assign w_badv    = exc_badvaddr[win_idx*32 +: 32];
  assign w_bd      = exc_bd[win_idx];
  assign w_code    = int_take ? EXC_INT : exc_code[win_idx*5 +: 5];

  // A winner at or before the MTC0 lane squashes it.
  assign mtc0_ok = mtc0_we & ~(win_any & (win_idx <= mtc0_lane));
  assign epc_fwd = mtc0_ok & (mtc0_addr == REG_EPC);

  assign flush    = win_any & ~rst;
  assign flush_pc = !take_eret ? EXC_VECTOR :
                    epc_fwd    ? mtc0_wdata : epc;

`ifdef CP0_TIMER_EN
  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0_ok && mtc0_addr == REG_COUNT),
    .compare_we (mtc0_ok && mtc0_addr == REG_COMPARE),
    .wdata      (mtc0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badv        <= '0;
      epc         <= '0;
      im          <= '0;
      exl         <= 1'b0;
      ie          <= 1'b0;
      bd          <= 1'b0;
      ip_hw       <= '0;
      ip_sw       <= '0;
      code        <= '0;
      int_pending <= 1'b0;
    end else begin
      ip_hw       <= hw_int;
      int_pending <= int_req & ~win_any;
      if (mtc0_ok) begin
        case (mtc0_addr)
          REG_STATUS: begin
            im  <= mtc0_wdata[15:8];
            exl <= mtc0_wdata[ST_EXL];
            ie  <= mtc0_wdata[ST_IE];
          end
          REG_CAUSE: ip_sw <= mtc0_wdata[9:8];
          REG_EPC:   epc   <= mtc0_wdata;
          default: ;
        endcase
      end
      // Exception state overrides any same-cycle MTC0 fields.
      if (take_exc) begin
        if (!exl) begin
          epc <= w_bd ? w_pc - 32'd4 : w_pc;
          bd  <= w_bd;
        end
        exl  <= 1'b1;
        code <= w_code;
        if (!int_take && exc_badv_vld[win_idx]) badv <= w_badv;
      end else if (take_eret) begin
        exl <= 1'b0;
      end
    end
  end

  always_comb begin
    mfc0_rdata = '0;
    case (mfc0_addr)
      REG_BADVADDR: mfc0_rdata = badv;
      REG_COUNT:    mfc0_rdata = count;
      REG_COMPARE:  mfc0_rdata = compare;
      REG_STATUS: begin
        mfc0_rdata         = STATUS_RST;
        mfc0_rdata[15:8]   = im;
        mfc0_rdata[ST_EXL] = exl;
        mfc0_rdata[ST_IE]  = ie;
      end
      REG_CAUSE: begin
        mfc0_rdata[CA_BD] = bd;
        mfc0_rdata[CA_TI] = ti;
        mfc0_rdata[15:8]  = ip;
        mfc0_rdata[6:2]   = code;
      end
      REG_EPC: mfc0_rdata = epc;
      default: mfc0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_mlane.sv
// Directed bench for cp0_mlane (LANES=2): vector table plus interrupt/reset/timer sequences.
module tb_cp0_mlane;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  commit_valid, exc_valid, exc_bd, exc_badv_vld, eret;
  logic [9:0]  exc_code;
  logic [63:0] exc_pc, exc_badvaddr;
  logic        mtc0_we;
  logic [0:0]  mtc0_lane;
  logic [4:0]  mtc0_addr, mfc0_addr;
  logic [31:0] mtc0_wdata, mfc0_rdata, flush_pc;
  logic [5:0]  hw_int;
  logic        flush, int_pending;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cp0_mlane #(.LANES(2), .EXC_VECTOR(32'hBFC0_0380), .COUNT_DIV(2)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badv_vld(exc_badv_vld), .exc_badvaddr(exc_badvaddr),
    .eret(eret), .mtc0_we(mtc0_we), .mtc0_lane(mtc0_lane),
    .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
    .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
    .hw_int(hw_int), .flush(flush), .flush_pc(flush_pc),
    .int_pending(int_pending)
  );

  typedef struct {
    string       nm;
    logic [1:0]  cv, ev;
    logic [9:0]  code;
    logic [63:0] pc;
    logic [1:0]  bd, bvld;
    logic [63:0] badv;
    logic [1:0]  er;
    logic        we;
    logic        ml;
    logic [4:0]  ma;
    logic [31:0] wd;
    logic        ef;
    logic [31:0] fpc;
    logic [4:0]  ra;
    logic [31:0] rv;
  } vec_t;

  vec_t vt[19];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    commit_valid = '0; exc_valid = '0; exc_code = '0; exc_pc = '0;
    exc_bd = '0; exc_badv_vld = '0; exc_badvaddr = '0; eret = '0;
    mtc0_we = 1'b0; mtc0_lane = '0; mtc0_addr = '0; mtc0_wdata = '0;
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] exp);
    mfc0_addr = a;
    #1 check(nm, mfc0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    idle();
    mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d;
    @(posedge clk);
    #1 idle();
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    commit_valid = v.cv; exc_valid = v.ev; exc_code = v.code; exc_pc = v.pc;
    exc_bd = v.bd; exc_badv_vld = v.bvld; exc_badvaddr = v.badv; eret = v.er;
    mtc0_we = v.we; mtc0_lane = v.ml; mtc0_addr = v.ma; mtc0_wdata = v.wd;
    #1 check({v.nm, ".flush"}, 32'(flush), 32'(v.ef));
    if (v.ef) check({v.nm, ".flush_pc"}, flush_pc, v.fpc);
    @(posedge clk);
    #1 idle();
    rd({v.nm, ".rd"}, v.ra, v.rv);
  endtask

  initial begin
    vt[0]  = '{"ov_sys", 2'b11, 2'b11, {5'h08, 5'h0C}, {32'h8000_0200, 32'h8000_0100},
               2'b00, 2'b00, 64'h0, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0,
               1'b1, 32'hBFC0_0380, 5'd14, 32'h8000_0100};
    vt[1]  = '{"cause_ov", 2'b00, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b00,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd13, 32'h0000_0030};
    vt[2]  = '{"status_exl", 2'b00, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b00,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd12, 32'h0040_0002};
    vt[3]  = '{"eret0", 2'b01, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b01,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h8000_0100, 5'd12, 32'h0040_0000};
    vt[4]  = '{"adel_bd", 2'b10, 2'b10, {5'h04, 5'h00}, {32'h8000_0204, 32'h0},
               2'b10, 2'b10, {32'h0000_1235, 32'h0}, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0,
               1'b1, 32'hBFC0_0380, 5'd14, 32'h8000_0200};
    vt[5]  = '{"cause_bd", 2'b00, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b00,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd13, 32'h8000_0010};
    vt[6]  = '{"badv", 2'b00, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b00,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd8, 32'h0000_1235};
    vt[7]  = '{"mtc0_fwd", 2'b10, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b10,
               1'b1, 1'b0, 5'd14, 32'hBFC0_1000, 1'b1, 32'hBFC0_1000, 5'd12, 32'h0040_0000};
    vt[8]  = '{"epc_fwd", 2'b00, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b00,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd14, 32'hBFC0_1000};
    vt[9]  = '{"mtc0_drop", 2'b01, 2'b01, {5'h00, 5'h0C}, {32'h0, 32'h8000_0300},
               2'b00, 2'b00, 64'h0, 2'b00, 1'b1, 1'b1, 5'd14, 32'h1234_5678,
               1'b1, 32'hBFC0_0380, 5'd14, 32'h8000_0300};
    vt[10] = '{"eret_same", 2'b01, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b01,
               1'b1, 1'b0, 5'd14, 32'h1111_0000, 1'b1, 32'h8000_0300, 5'd14, 32'h8000_0300};
    vt[11] = '{"bp", 2'b01, 2'b01, {5'h00, 5'h09}, {32'h0, 32'h8000_0400},
               2'b00, 2'b00, 64'h0, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0,
               1'b1, 32'hBFC0_0380, 5'd14, 32'h8000_0400};
    vt[12] = '{"exl_hold", 2'b11, 2'b10, {5'h0A, 5'h00}, {32'h8000_0500, 32'h8000_0498},
               2'b10, 2'b00, 64'h0, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0,
               1'b1, 32'hBFC0_0380, 5'd14, 32'h8000_0400};
    vt[13] = '{"cause_ri", 2'b00, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b00,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd13, 32'h0000_0028};
    vt[14] = '{"cause_sw", 2'b00, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b00,
               1'b1, 1'b0, 5'd13, 32'hFFFF_FFFF, 1'b0, 32'h0, 5'd13, 32'h0000_0328};
    vt[15] = '{"unmapped", 2'b00, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b00,
               1'b1, 1'b0, 5'd3, 32'hFFFF_FFFF, 1'b0, 32'h0, 5'd3, 32'h0};
    vt[16] = '{"badv_ro", 2'b00, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b00,
               1'b1, 1'b0, 5'd8, 32'hDEAD_BEEF, 1'b0, 32'h0, 5'd8, 32'h0000_1235};
    vt[17] = '{"status_wr", 2'b00, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b00,
               1'b1, 1'b0, 5'd12, 32'h0000_0300, 1'b0, 32'h0, 5'd12, 32'h0040_0300};
    vt[18] = '{"cause_clr", 2'b00, 2'b00, 10'h0, 64'h0, 2'b00, 2'b00, 64'h0, 2'b00,
               1'b1, 1'b0, 5'd13, 32'h0, 1'b0, 32'h0, 5'd13, 32'h0000_0028};

    idle();
    hw_int = '0;
    mfc0_addr = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst.flush", 32'(flush), 32'd0);
    check("rst.int_pending", 32'(int_pending), 32'd0);
    rd("rst.status", 5'd12, 32'h0040_0000);
    rd("rst.cause", 5'd13, 32'h0);
    rd("rst.epc", 5'd14, 32'h0);

    for (int i = 0; i < 19; i++) apply(vt[i]);

    // Hardware interrupt: IP one cycle, int_pending one more, then taken on lane 0.
    mtc0(5'd12, 32'h0040_8001);
    @(negedge clk);
    hw_int = 6'b100000;
    #1 check("int.pend0", 32'(int_pending), 32'd0);
    @(posedge clk);
    #1 check("int.pend1", 32'(int_pending), 32'd0);
    @(posedge clk);
    #1 check("int.pend2", 32'(int_pending), 32'd1);
    @(negedge clk);
    commit_valid = 2'b01;
    exc_pc = {32'h0, 32'h8000_0600};
    #1 check("int.flush", 32'(flush), 32'd1);
    check("int.flush_pc", flush_pc, 32'hBFC0_0380);
    @(posedge clk);
    #1 check("int.once", 32'(flush), 32'd0);
    check("int.pend_clr", 32'(int_pending), 32'd0);
    idle();
    rd("int.cause", 5'd13, 32'h0000_8000);
    rd("int.epc", 5'd14, 32'h8000_0600);
    hw_int = '0;

    // Async reset while a flush is being driven.
    @(negedge clk);
    commit_valid = 2'b01; exc_valid = 2'b01;
    exc_code = {5'h00, 5'h0C}; exc_pc = {32'h0, 32'h8000_0700};
    #1 check("rstf.pre", 32'(flush), 32'd1);
    rst = 1'b1;
    #1 check("rstf.flush", 32'(flush), 32'd0);
    check("rstf.int_pending", 32'(int_pending), 32'd0);
    rd("rstf.status", 5'd12, 32'h0040_0000);
    rd("rstf.epc", 5'd14, 32'h0);
    rd("rstf.cause", 5'd13, 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;

`ifdef CP0_TIMER_EN
    begin
      logic        hit;
      logic [31:0] cnt;
      hit = 1'b0;
      cnt = '0;
      mtc0(5'd9, 32'd0);
      mtc0(5'd11, 32'd5);
      for (int i = 0; i < 60 && !hit; i++) begin
        @(posedge clk);
        #1 mfc0_addr = 5'd13;
        #1 if (mfc0_rdata[30]) begin
          hit = 1'b1;
          mfc0_addr = 5'd9;
          #1 cnt = mfc0_rdata;
        end
      end
      check("ti.set", 32'(hit), 32'd1);
      check("ti.count", 32'(cnt == 32'd5 || cnt == 32'd6), 32'd1);
      mtc0(5'd11, 32'd0);
      mfc0_addr = 5'd13;
      #1 check("ti.clr", 32'(mfc0_rdata[30]), 32'd0);
    end
`else
    mtc0(5'd9, 32'd77);
    rd("count_off", 5'd9, 32'h0);
    mtc0(5'd11, 32'd5);
    rd("compare_off", 5'd11, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
